// File: rtl/sipo_pkg.sv
// Shared types and defaults for the serial frame receiver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sipo_pkg;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_PARITY_EN = 1;

  // Wide enough to count up to DATA_W-1 for the largest legal DATA_W (16).
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

endpackage

// File: rtl/sipo_frame_rx_if.sv
// Bus bundle between the serial receiver and its upstream line / downstream consumer.
// Latency: n/a (wires only).
// Backpressure: out_valid/out_ready handshake on the payload side.
// Signals: serial_in (line in), out_data/out_valid/out_ready (payload handshake),
//          frame_err/overrun (status pulses).
// master = receiver side, slave = line driver / consumer side.
interface sipo_frame_rx_if #(
  parameter int DATA_W = 8
);
  logic              serial_in;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              frame_err;
  logic              overrun;

  modport master (
    input  serial_in,
    input  out_ready,
    output out_data,
    output out_valid,
    output frame_err,
    output overrun
  );

  modport slave (
    output serial_in,
    output out_ready,
    input  out_data,
    input  out_valid,
    input  frame_err,
    input  overrun
  );
endinterface

// File: rtl/sipo_shift_reg.sv
// LSB-first serial-in parallel-out shift register with synchronous clear.
// Latency: one cycle per bit; q reflects the bit shifted on the previous edge.
// Backpressure: none; shifts whenever shift_en is high.
// Ports: clk, rst_n (async active-low), clr (sync clear, wins over shift),
//        shift_en, din (serial bit), q (parallel word).
module sipo_shift_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         shift_en,
  input  logic         din,
  output logic [W-1:0] q
);

  // New bits enter at the MSB and move down, so after W shifts the first
  // bit received sits in q[0].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (shift_en) begin
      q <= {din, q[W-1:1]};
    end
  end

endmodule

// File: rtl/sipo_frame_rx.sv
// Serial frame receiver: start bit, DATA_W data bits LSB first, optional even parity, stop bit.
// Latency: payload valid on the stop-sampling edge (edge DATA_W+2+PARITY_EN from start edge).
// Backpressure: holds one frame; a good frame arriving while full and not consumed is dropped (overrun).
// Ports: clk, rst_n (async active-low), bus (master modport: serial_in, out_ready in;
//        out_data, out_valid, frame_err, overrun out).
module sipo_frame_rx
  import sipo_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int PARITY_EN = DEF_PARITY_EN
) (
  input  logic            clk,
  input  logic            rst_n,
  sipo_frame_rx_if.master bus
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] sr_q;
  logic              par_err_q;

  logic sr_clr, sr_shift, cnt_clr, cnt_inc, par_smp, stop_smp;
  logic frame_good, consume;

  sipo_shift_reg #(
    .W (DATA_W)
  ) u_shift (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (sr_clr),
    .shift_en (sr_shift),
    .din      (bus.serial_in),
    .q        (sr_q)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and per-state control strobes.
  always_comb begin
    state_d  = state_q;
    sr_clr   = 1'b0;
    sr_shift = 1'b0;
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
    par_smp  = 1'b0;
    stop_smp = 1'b0;
    case (state_q)
      IDLE: begin
        if (!bus.serial_in) begin
          state_d = DATA;
          sr_clr  = 1'b1;
          cnt_clr = 1'b1;
        end
      end
      DATA: begin
        sr_shift = 1'b1;
        cnt_inc  = 1'b1;
        if (cnt_q == LAST_BIT) begin
          state_d = (PARITY_EN != 0) ? PARITY : STOP;
        end
      end
      PARITY: begin
        par_smp = 1'b1;
        state_d = STOP;
      end
      STOP: begin
        // Return straight to IDLE so a start bit on the next cycle is caught.
        stop_smp = 1'b1;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Bit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (cnt_clr) begin
      cnt_q <= '0;
    end else if (cnt_inc) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Even parity: all data bits are in sr_q by the time PARITY samples, so the
  // error is simply the XOR of the whole word with the parity bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_err_q <= 1'b0;
    end else if (sr_clr) begin
      par_err_q <= 1'b0;
    end else if (par_smp) begin
      par_err_q <= (^sr_q) ^ bus.serial_in;
    end
  end

  assign frame_good = bus.serial_in & ~par_err_q;
  assign consume    = bus.out_valid & bus.out_ready;

  // Output holding register and status pulses. frame_err and overrun come
  // from disjoint branches of the stop-edge decision, so they never coincide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_data  <= '0;
      bus.out_valid <= 1'b0;
      bus.frame_err <= 1'b0;
      bus.overrun   <= 1'b0;
    end else begin
      bus.frame_err <= 1'b0;
      bus.overrun   <= 1'b0;
      if (stop_smp) begin
        if (frame_good) begin
          if (!bus.out_valid || consume) begin
            // Slot is free or being freed this edge: take the new frame.
            bus.out_data  <= sr_q;
            bus.out_valid <= 1'b1;
          end else begin
            bus.overrun <= 1'b1;
          end
        end else begin
          bus.frame_err <= 1'b1;
          if (consume) begin
            bus.out_valid <= 1'b0;
          end
        end
      end else if (consume) begin
        bus.out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sipo_frame_rx.sv
// Bench for sipo_frame_rx: directed frames with a frame-level reference model.
// Latency: n/a.
// Backpressure: out_ready driven directly by the stimulus.
module tb_sipo_frame_rx;

  localparam int DW = 8;
  localparam int PE = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  sipo_frame_rx_if #(.DATA_W(DW)) bus ();

  sipo_frame_rx #(
    .DATA_W    (DW),
    .PARITY_EN (PE)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- Frame-level reference model ----------------
  // The driver announces each complete frame together with the edge index at
  // which its stop bit is sampled; the model applies the handshake rules at
  // that edge using only the frame word and its framing bits.
  typedef struct {
    int          at_edge;
    logic [DW-1:0] data;
    logic        par_bit;
    logic        stop_bit;
  } frame_t;

  frame_t        pend_q[$];
  int            edge_cnt = 0;
  logic [DW-1:0] m_data  = '0;
  logic          m_valid = 1'b0;
  logic          m_ferr  = 1'b0;
  logic          m_ovr   = 1'b0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_data  = '0;
      m_valid = 1'b0;
      m_ferr  = 1'b0;
      m_ovr   = 1'b0;
      pend_q.delete();
    end else begin
      logic took;
      logic ok;
      frame_t f;
      took   = (m_valid && bus.out_ready);
      m_ferr = 1'b0;
      m_ovr  = 1'b0;
      if (pend_q.size() > 0 && pend_q[0].at_edge == edge_cnt) begin
        f  = pend_q.pop_front();
        ok = f.stop_bit && (PE == 0 || ((^f.data) ^ f.par_bit) == 1'b0);
        if (!ok) begin
          m_ferr = 1'b1;
          if (took) m_valid = 1'b0;
        end else if (!m_valid || took) begin
          m_data  = f.data;
          m_valid = 1'b1;
        end else begin
          m_ovr = 1'b1;
        end
      end else if (took) begin
        m_valid = 1'b0;
      end
    end
  end

  // Per-cycle compare, away from the active edge.
  logic cmp_en = 1'b0;
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("out_valid", {31'd0, bus.out_valid}, {31'd0, m_valid});
      chk("out_data",  {24'd0, bus.out_data},  {24'd0, m_data});
      chk("frame_err", {31'd0, bus.frame_err}, {31'd0, m_ferr});
      chk("overrun",   {31'd0, bus.overrun},   {31'd0, m_ovr});
      if (bus.frame_err && bus.overrun) chk("err_ovr_excl", 32'd1, 32'd0);
    end
  end

  // ---------------- Stimulus ----------------
  task automatic bit_cycle(input logic b);
    bus.serial_in = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic flip_par,
                            input logic stop_b, input logic rdy_at_stop);
    frame_t f;
    logic p;
    p = (^d) ^ flip_par;
    bit_cycle(1'b0);
    for (int i = 0; i < DW; i++) bit_cycle(d[i]);
    if (PE != 0) bit_cycle(p);
    f.at_edge  = edge_cnt;
    f.data     = d;
    f.par_bit  = p;
    f.stop_bit = stop_b;
    pend_q.push_back(f);
    if (rdy_at_stop) bus.out_ready = 1'b1;
    bit_cycle(stop_b);
    if (rdy_at_stop) bus.out_ready = 1'b0;
    bus.serial_in = 1'b1;
  endtask

  task automatic idle(input int n);
    bus.serial_in = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    n_errors++;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1);
  end

  initial begin
    int e0;
    bus.serial_in = 1'b1;
    bus.out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_data",  {24'd0, bus.out_data},  32'd0);
    chk("rst_ferr",  {31'd0, bus.frame_err}, 32'd0);
    chk("rst_ovr",   {31'd0, bus.overrun},   32'd0);
    rst_n = 1'b1;
    cmp_en = 1'b1;
    idle(3);

    // Good frame 0xA5, parity 0: valid right after edge 11 of the frame.
    e0 = edge_cnt;
    send_frame(8'hA5, 1'b0, 1'b1, 1'b0);
    chk("good_edge_no", edge_cnt - e0, 32'd11);
    chk("good_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("good_data",  {24'd0, bus.out_data},  32'h0000_00A5);
    chk("good_ferr",  {31'd0, bus.frame_err}, 32'd0);
    idle(3);

    // Parity error: 0xA5 with parity bit 1.
    send_frame(8'hA5, 1'b1, 1'b1, 1'b0);
    chk("par_ferr",  {31'd0, bus.frame_err}, 32'd1);
    chk("par_valid", {31'd0, bus.out_valid}, 32'd0);
    idle(1);
    chk("par_ferr_pulse", {31'd0, bus.frame_err}, 32'd0);
    idle(2);

    // Stop error: 0x3C, correct parity, stop 0.
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    chk("stop_ferr",  {31'd0, bus.frame_err}, 32'd1);
    chk("stop_valid", {31'd0, bus.out_valid}, 32'd0);
    idle(3);

    // Overrun: 0x3C then 0xC3 with no consumer.
    bus.out_ready = 1'b0;
    send_frame(8'h3C, 1'b0, 1'b1, 1'b0);
    send_frame(8'hC3, 1'b0, 1'b1, 1'b0);
    chk("ovr_pulse", {31'd0, bus.overrun},   32'd1);
    chk("ovr_data",  {24'd0, bus.out_data},  32'h0000_003C);
    chk("ovr_ferr",  {31'd0, bus.frame_err}, 32'd0);
    idle(2);
    chk("ovr_hold", {24'd0, bus.out_data}, 32'h0000_003C);
    bus.out_ready = 1'b1;
    idle(1);
    chk("ovr_drain", {31'd0, bus.out_valid}, 32'd0);
    idle(2);

    // Simultaneous completion and consume.
    bus.out_ready = 1'b0;
    send_frame(8'h11, 1'b0, 1'b1, 1'b0);
    send_frame(8'h22, 1'b0, 1'b1, 1'b1);
    chk("sim_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("sim_data",  {24'd0, bus.out_data},  32'h0000_0022);
    chk("sim_ovr",   {31'd0, bus.overrun},   32'd0);
    bus.out_ready = 1'b1;
    idle(3);

    // Reset in the middle of a frame, after 4 data bits of 0xFF.
    bit_cycle(1'b0);
    for (int i = 0; i < 4; i++) bit_cycle(1'b1);
    bus.serial_in = 1'b1;
    rst_n = 1'b0;
    #2;
    chk("mid_rst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("mid_rst_data",  {24'd0, bus.out_data},  32'd0);
    @(posedge clk);
    #1;
    chk("mid_rst_ferr", {31'd0, bus.frame_err}, 32'd0);
    chk("mid_rst_ovr",  {31'd0, bus.overrun},   32'd0);
    rst_n = 1'b1;
    idle(12);
    chk("post_rst_quiet", {31'd0, bus.out_valid}, 32'd0);
    bus.out_ready = 1'b0;
    send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
    chk("post_rst_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("post_rst_data",  {24'd0, bus.out_data},  32'h0000_005A);
    bus.out_ready = 1'b1;
    idle(4);
    chk("end_valid", {31'd0, bus.out_valid}, 32'd0);

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sipo_frame_rx.md
SIPO_FRAME_RX -- requirements
Module: sipo_frame_rx

Interface
REQ-001 The block SHALL expose parameter DATA_W, default 8, meaning payload bits per frame (legal range 4..16).
REQ-002 The block SHALL expose parameter PARITY_EN, default 1, meaning 1 = even-parity bit present after the data bits, 0 = no parity bit.
REQ-003 The port clk SHALL be an input of width 1: the single clock, all state updated on its rising edge.
REQ-004 The port rst_n SHALL be an input of width 1: reset, asynchronous and active-low.
REQ-005 The port serial_in SHALL be an input of width 1: serial line, idle high, one bit per clk cycle, driven by the upstream shift-register stage.
REQ-006 The port out_data SHALL be an output of width DATA_W: the received payload.
REQ-007 The port out_valid SHALL be an output of width 1: out_data holds an unconsumed frame.
REQ-008 The port out_ready SHALL be an input of width 1: the consumer accepts out_data this cycle.
REQ-009 The port frame_err SHALL be an output of width 1: one-cycle pulse on a parity or stop-bit failure.
REQ-010 The port overrun SHALL be an output of width 1: one-cycle pulse when a good frame is dropped because the output is occupied.

Function
REQ-011 The FSM SHALL have the states IDLE, DATA, PARITY and STOP.
REQ-012 In IDLE, serial_in=0 on a rising edge SHALL be taken as the start bit: go to DATA and clear the bit counter. serial_in=1 SHALL keep the FSM in IDLE.
REQ-013 DATA SHALL shift in one bit per cycle, LSB first; after DATA_W bits it SHALL go to PARITY if PARITY_EN=1, otherwise to STOP.
REQ-014 PARITY SHALL sample one bit and record an error if the XOR of the data bits and the parity bit is 1, then go to STOP.
REQ-015 STOP SHALL sample one bit and SHALL return to IDLE on the same edge, so the next start bit can be taken on the very next cycle.
REQ-016 A frame SHALL be good when the stop bit = 1 and there is no parity error; otherwise frame_err SHALL pulse high for exactly one cycle, on the cycle after the stop-sampling edge, and the payload SHALL be discarded.
REQ-017 A good frame SHALL be loaded into out_data and SHALL set out_valid on the stop-sampling edge. With DATA_W=8 and PARITY_EN=1, that is edge 11, counting the start-bit edge as edge 1.
REQ-018 While out_valid=1 and out_ready=0, out_data SHALL be held stable.
REQ-019 Handshake: the frame SHALL be consumed on the edge where out_valid and out_ready are both high; out_valid SHALL then clear unless REQ-020 applies.
REQ-020 If a good frame completes on the same edge that the old frame is consumed, the new frame SHALL load and out_valid SHALL stay 1.
REQ-021 If a good frame completes while out_valid=1 and out_ready=0, the new frame SHALL be dropped, out_data SHALL be unchanged, and overrun SHALL pulse for one cycle.
REQ-022 frame_err and overrun SHALL never be asserted in the same cycle.
REQ-023 out_ready SHALL have no effect when out_valid=0.

Reset
REQ-024 While rst_n=0, the FSM SHALL be in IDLE, the bit counter and shift register SHALL be 0, out_data SHALL be 0, and out_valid, frame_err and overrun SHALL be 0.
REQ-025 Reset asserted mid-frame SHALL abandon the frame; after release the block SHALL wait in IDLE for a new start bit, and no partial frame SHALL ever be output.

Structure
REQ-026 A shared package sipo_pkg SHALL hold the state enum type and the default DATA_W and PARITY_EN constants.
REQ-027 The DATA_W-bit LSB-first shift register with shift enable and clear SHALL be a sub-module named sipo_shift_reg; the FSM, parity logic and output handshake SHALL live in sipo_frame_rx.

Verification
REQ-028 Good frame: send start 0, data 0xA5 LSB first, parity 0, stop 1, with out_ready=1 -> out_valid=1 after edge 11, out_data=0xA5, frame_err=0.
REQ-029 Parity error: send 0xA5 with parity 1 and stop 1 -> one-cycle frame_err pulse, out_valid stays 0.
REQ-030 Stop error: send 0x3C with correct parity 0 and stop 0 -> one-cycle frame_err pulse, no out_valid.
REQ-031 Overrun: send 0x3C then 0xC3 back-to-back with out_ready=0 -> out_data=0x3C held, one overrun pulse at the second stop edge; then raise out_ready -> out_valid clears on the next edge.
REQ-032 Simultaneous completion: back-to-back 0x11 then 0x22, with out_ready pulsed exactly on the second stop edge -> out_valid stays 1, out_data=0x22, no overrun.
REQ-033 Reset mid-frame: assert rst_n=0 after 4 data bits, release, then send 0x5A -> the only output is 0x5A, with all outputs 0 during reset.
